// File: rtl/instr_stream_loader.sv
// instr_stream_loader
//
// Receive side of the byte-serial instruction download path. A framed byte
// stream (start 0xFE, end 0xFF) is assembled into little-endian 32-bit words
// that are written to instruction memory at consecutive word addresses from 0.
// The core is held off until a complete framed program has arrived.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_ni         : asynchronous active-low reset
//   instr_valid_i  : instr_i carries a byte this cycle
//   instr_i        : stream byte
//   imem_we_o      : one-cycle write strobe to instruction memory
//   imem_addr_o    : word address of the write (holds when strobe is low)
//   imem_wdata_o   : word being written (holds when strobe is low)
//   load_busy_o    : high while in LOAD
//   load_done_o    : sticky end-of-load flag, cleared by the next start byte
//   cpu_run_o      : core enable, high only in DONE
//   word_cnt_o     : words written in this load, saturates at DEPTH
//   overflow_err_o : sticky, more than DEPTH words were sent in this load
//   state_o        : current FSM state (debug observation)
//
// Handshake: the stream is valid-only with no back-pressure. A byte is
// consumed on every rising edge where instr_valid_i is high; the loader is
// always able to accept it, so there is no ready signal.

module instr_stream_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_valid_i,
    input  logic [7:0]        instr_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              load_busy_o,
    output logic              load_done_o,
    output logic              cpu_run_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              overflow_err_o,
    output logic [1:0]        state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] START_BYTE = 8'hFE;
    localparam logic [7:0] END_BYTE   = 8'hFF;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [1:0]        byte_cnt;
    logic [23:0]       byte_buf;
    logic [ADDR_W-1:0] word_addr;

    logic aligned;
    logic start_load;
    logic end_load;
    logic data_byte;

    // Markers are only recognised on a word boundary; inside a word every
    // byte is data, so a pending partial word can never end the load.
    always_comb begin
        aligned    = (byte_cnt == 2'd0);
        start_load = instr_valid_i && (instr_i == START_BYTE) &&
                     ((state != S_LOAD) || aligned);
        end_load   = instr_valid_i && (instr_i == END_BYTE) &&
                     (state == S_LOAD) && aligned;
        data_byte  = instr_valid_i && (state == S_LOAD) && !start_load && !end_load;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= S_IDLE;
            byte_cnt       <= 2'd0;
            byte_buf       <= 24'd0;
            word_addr      <= '0;
            imem_we_o      <= 1'b0;
            imem_addr_o    <= '0;
            imem_wdata_o   <= 32'd0;
            load_done_o    <= 1'b0;
            word_cnt_o     <= '0;
            overflow_err_o <= 1'b0;
        end else begin
            imem_we_o <= 1'b0;
            if (start_load) begin
                state          <= S_LOAD;
                byte_cnt       <= 2'd0;
                byte_buf       <= 24'd0;
                word_addr      <= '0;
                load_done_o    <= 1'b0;
                word_cnt_o     <= '0;
                overflow_err_o <= 1'b0;
            end else if (end_load) begin
                state       <= S_DONE;
                load_done_o <= 1'b1;
            end else if (data_byte) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: byte_buf[7:0]   <= instr_i;
                    2'd1: byte_buf[15:8]  <= instr_i;
                    2'd2: byte_buf[23:16] <= instr_i;
                    default: begin
                        if (word_cnt_o < DEPTH_CNT) begin
                            imem_we_o    <= 1'b1;
                            imem_addr_o  <= word_addr;
                            imem_wdata_o <= {instr_i, byte_buf};
                            word_cnt_o   <= word_cnt_o + CNT_ONE;
                            // Address stops at the last word instead of
                            // wrapping back over already written memory.
                            if (word_addr != LAST_ADDR) begin
                                word_addr <= word_addr + ADDR_ONE;
                            end
                        end else begin
                            overflow_err_o <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign load_busy_o = (state == S_LOAD);
    assign cpu_run_o   = (state == S_DONE);
    assign state_o     = state;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed bench for instr_stream_loader: framing, stalls, markers as data,
// overflow and asynchronous reset, with a write scoreboard.

module tb_instr_stream_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int W      = ADDR_W + 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic              clk;
    logic              rst_n;
    logic              instr_valid;
    logic [7:0]        instr;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              load_busy;
    logic              load_done;
    logic              cpu_run;
    logic [ADDR_W:0]   word_cnt;
    logic              overflow_err;
    logic [1:0]        state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    instr_stream_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_valid_i  (instr_valid),
        .instr_i        (instr),
        .imem_we_o      (imem_we),
        .imem_addr_o    (imem_addr),
        .imem_wdata_o   (imem_wdata),
        .load_busy_o    (load_busy),
        .load_done_o    (load_done),
        .cpu_run_o      (cpu_run),
        .word_cnt_o     (word_cnt),
        .overflow_err_o (overflow_err),
        .state_o        (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic send_byte(input logic [7:0] b);
        instr_valid = 1'b1;
        instr       = b;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_write(input int addr, input logic [31:0] data);
        exp_q.push_back({ADDR_W'(addr), data});
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs",
            {imem_we, imem_addr, imem_wdata, load_busy, load_done, cpu_run, word_cnt, overflow_err},
            0);
        chk("rst_state", state, S_IDLE);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // scoreboard: every strobe cycle must match the next expected write
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexp_write", imem_we, 1'b0);
            end else begin
                chk("write", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        instr_valid = 1'b0;
        instr       = 8'h00;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs",
            {imem_we, imem_addr, imem_wdata, load_busy, load_done, cpu_run, word_cnt, overflow_err},
            0);
        chk("reset_state", state, S_IDLE);
        rst_n = 1'b1;
        idle(1);

        // basic load
        send_byte(8'hFE);
        chk("start_busy", load_busy, 1'b1);
        chk("start_state", state, S_LOAD);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50);
        exp_write(0, 32'h00500093);
        send_byte(8'h00);
        chk("w0_strobe", {imem_we, imem_addr, imem_wdata}, {1'b1, 6'd0, 32'h00500093});
        chk("w0_cnt", word_cnt, 7'd1);
        send_byte(8'h13);
        chk("w0_strobe_1cyc", imem_we, 1'b0);
        chk("w0_addr_hold", {imem_addr, imem_wdata}, {6'd0, 32'h00500093});
        send_byte(8'h01); send_byte(8'h10);
        exp_write(1, 32'h00100113);
        send_byte(8'h00);
        chk("w1_strobe", {imem_we, imem_addr, imem_wdata}, {1'b1, 6'd1, 32'h00100113});
        send_byte(8'hFF);
        chk("basic_done", {load_busy, load_done, cpu_run, word_cnt}, {3'b011, 7'd2});
        chk("basic_state", state, S_DONE);

        // framing: bytes before the start marker are discarded
        do_reset();
        send_byte(8'h00); send_byte(8'h13); send_byte(8'hFF);
        chk("preframe_state", state, S_IDLE);
        chk("preframe_outs", {load_busy, load_done, cpu_run, word_cnt}, 10'd0);

        // stalls between the bytes of one word
        send_byte(8'hFE);
        send_byte(8'h93); idle(3);
        send_byte(8'h02); idle(3);
        send_byte(8'hA0); idle(3);
        exp_write(0, 32'h00A00293);
        send_byte(8'h00);
        chk("stall_strobe", {imem_we, imem_addr, imem_wdata}, {1'b1, 6'd0, 32'h00A00293});
        send_byte(8'hFF);
        chk("stall_done", {cpu_run, word_cnt}, {1'b1, 7'd1});

        // marker bytes inside a word are data; DONE -> LOAD on FE
        send_byte(8'hFE);
        chk("reload_clears", {load_busy, load_done, cpu_run, word_cnt}, {3'b100, 7'd0});
        exp_write(0, 32'hFFF00093);
        send_word(32'hFFF00093);
        chk("mk0_state", state, S_LOAD);
        exp_write(1, 32'h0000FE13);
        send_word(32'h0000FE13);
        chk("mk1_state", {state, word_cnt}, {S_LOAD, 7'd2});
        send_byte(8'hFE);
        chk("restart_cnt", {state, word_cnt}, {S_LOAD, 7'd0});
        exp_write(0, 32'h00100113);
        send_word(32'h00100113);
        chk("restart_cnt1", word_cnt, 7'd1);
        send_byte(8'hFF);
        chk("mk_done", state, S_DONE);

        // overflow: 65 words into 64-word memory
        send_byte(8'hFE);
        for (int i = 0; i < DEPTH; i++) begin
            exp_write(i, 32'h00000013 | (32'(i) << 24));
            send_word(32'h00000013 | (32'(i) << 24));
        end
        chk("full_cnt", {word_cnt, overflow_err}, {7'd64, 1'b0});
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
        chk("ovf_before", overflow_err, 1'b0);
        send_byte(8'h77);
        chk("ovf_set", {imem_we, overflow_err, word_cnt}, {1'b0, 1'b1, 7'd64});
        chk("ovf_addr_hold", {imem_addr, imem_wdata}, {6'd63, 32'h3F000013});
        send_byte(8'hFF);
        chk("ovf_done", {state, cpu_run, overflow_err}, {S_DONE, 1'b1, 1'b1});
        send_byte(8'hFE);
        chk("ovf_cleared", {overflow_err, word_cnt, cpu_run}, {1'b0, 7'd0, 1'b0});
        send_byte(8'hFF);

        // reset mid-word
        send_byte(8'hFE);
        exp_write(0, 32'h11111113);
        send_word(32'h11111113);
        exp_write(1, 32'h22222213);
        send_word(32'h22222213);
        send_byte(8'h13); send_byte(8'h33);
        do_reset();
        send_byte(8'hFE);
        exp_write(0, 32'h00400513);
        send_word(32'h00400513);
        chk("post_rst_strobe", {imem_we, imem_addr, imem_wdata}, {1'b1, 6'd0, 32'h00400513});
        send_byte(8'hFF);
        chk("post_rst_done", {cpu_run, word_cnt}, {1'b1, 7'd1});

        idle(2);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_stream_loader.md
# instr_stream_loader

Receive side of the byte-serial instruction download path into `CPU`. Takes the 8-bit `instr_i` stream (one byte per valid cycle, framed by start byte 0xFE and end byte 0xFF) and assembles little-endian 32-bit words. Writes each word into instruction memory at consecutive word addresses starting at 0. Holds the core off (`cpu_run_o` low) until a complete, framed program has been received.

## Interface
- `DEPTH`, 64, instruction memory depth in words
- `ADDR_W`, 6, word-address width (log2 DEPTH)

- `clk_i`  in  1  clock; all state changes on the rising edge
- `rst_ni`  in  1  reset; asynchronous, active-low
- `instr_valid_i`  in  1  `instr_i` carries a byte this cycle
- `instr_i`  in  8  stream byte
- `imem_we_o`  out  1  one-cycle write strobe to instruction memory
- `imem_addr_o`  out  ADDR_W  word address of the write
- `imem_wdata_o`  out  32  word being written
- `load_busy_o`  out  1  high while in LOAD
- `load_done_o`  out  1  sticky: end byte received; cleared by the next start byte
- `cpu_run_o`  out  1  core enable; high only in DONE
- `word_cnt_o`  out  ADDR_W+1  words written this load; saturates at DEPTH
- `overflow_err_o`  out  1  sticky: more than DEPTH words were sent in this load

## Operation
- The block has three states: IDLE, LOAD and DONE.
- A byte is consumed only on an edge where `instr_valid_i`=1. Bytes with valid low are ignored in every state. Valid low mid-word stalls assembly without losing bytes already captured.
- IDLE:
  - Byte 0xFE moves the block to LOAD.
  - Any other byte is discarded.
- Entering LOAD (from any state) clears:
  - `byte_cnt` (2-bit) and `word_addr`
  - `word_cnt_o`, `load_done_o` and `overflow_err_o`
- LOAD, with `byte_cnt`=0 (word-aligned):
  - 0xFF moves the block to DONE.
  - 0xFE restarts the load: it re-enters LOAD with everything cleared.
  - Any other byte is data.
  - Markers are legal here because no RV32 instruction has low byte 0xFE or 0xFF (those opcode bits are not 32-bit encodings).
- LOAD, with `byte_cnt`≠0: every byte, including 0xFE and 0xFF, is data.
- Data assembly:
  - Byte k of a word (k = `byte_cnt`) goes to bits [8k+7:8k]. The first byte received is the LSB.
  - `byte_cnt` wraps 3→0.
- On the 4th byte of a word:
  - If `word_cnt_o` < DEPTH: issue a write of {byte3, byte2, byte1, byte0} at `word_addr`, then increment `word_addr` and `word_cnt_o`.
  - Otherwise: drop the write and set `overflow_err_o`. `word_addr` does not wrap.
- DONE:
  - `cpu_run_o`=1 and `load_done_o`=1.
  - 0xFE starts a reload (to LOAD); `cpu_run_o` drops.
  - Other bytes are ignored.
- A partial word (1–3 bytes) pending when a marker would be seen cannot end the load, because those bytes are data. Only an aligned 0xFF terminates.

## Timing
- Reset (asynchronous, any state, including mid-word) forces:
  - state IDLE
  - all outputs 0: `imem_we_o`, `imem_addr_o`, `imem_wdata_o`, `load_busy_o`, `load_done_o`, `cpu_run_o`, `word_cnt_o`, `overflow_err_o`
  - internal byte buffer and counters 0
  No partial write occurs on reset.
- All outputs are registered; no combinational path from input to output.
- Write latency: the 4th byte is sampled at edge N. `imem_we_o`, `imem_addr_o` and `imem_wdata_o` are valid for exactly the cycle after edge N. `imem_we_o` returns to 0 at edge N+1. `word_cnt_o` updates at edge N.
- `imem_addr_o` and `imem_wdata_o` hold their last values while `imem_we_o`=0.
- Marker timing:
  - Start byte sampled at edge N: `load_busy_o`=1 after edge N.
  - End byte sampled at edge M: `load_busy_o`=0 and `load_done_o`=`cpu_run_o`=1 after edge M.
- End byte on the cycle immediately after a word's 4th byte is legal. The write strobe and the DONE transition occur in consecutive cycles.
- Maximum throughput is one byte per cycle, i.e. one write every 4 cycles.

## Test plan
- Reset: hold `rst_ni`=0 for 2 cycles, then release → all outputs 0, state IDLE.
- Basic load: send FE, 93 00 50 00, 13 01 10 00, FF back-to-back →
  - write addr 0 data 0x00500093
  - write addr 1 data 0x00100113
  - each `imem_we_o` pulse is 1 cycle, one cycle after its 4th byte
  - `word_cnt_o`=2; `load_done_o`=`cpu_run_o`=1 the cycle after FF
- Framing and stalls:
  - Send 00, 13, FF before FE → no writes, state IDLE.
  - Insert valid-low gaps of 3 cycles between the bytes of word 0x00A00293 → single write of 0x00A00293 at addr 0.
- Marker bytes as data:
  - Send word 93 00 F0 FF and word 13 FE 00 00 → writes 0xFFF00093 and 0x0000FE13, no state change.
  - Send aligned FE mid-load → `word_cnt_o` returns to 0 and the next word is written at addr 0.
- Overflow: send FE, 65 words, FF →
  - writes at addr 0..63 only
  - `word_cnt_o`=64; `overflow_err_o`=1 from the 65th word's 4th byte
  - DONE reached
  - a following FE clears `overflow_err_o`
- Reset mid-operation: assert `rst_ni` low after 2 bytes of the 3rd word →
  - immediate all-zero outputs, no write
  - after release, a new FE load starts writing at addr 0
